// File: rtl/ring_slot_buffer.sv
// ring_slot_buffer: slot store for a ring-router input port, filled via the empty-slot finder
// and drained in arrival order over a valid/ready handshake.
module ring_slot_buffer #(
   parameter int BUFFER_SIZE = 4,
   parameter int PACKET_SIZE = 49,
   parameter int PTR_LEN     = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [PACKET_SIZE-1:0]             in_pkt,
   output logic                               in_ready,
   input  logic [PTR_LEN-1:0]                 empty_pos,
   input  logic                               empty_pos_found,
   output logic [BUFFER_SIZE*PACKET_SIZE-1:0] buffer_flat,
   output logic [PACKET_SIZE-1:0]             out_pkt,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [PTR_LEN:0]                   occupancy,
   output logic                               protocol_err
);
   localparam logic [PTR_LEN:0] FULL = (PTR_LEN+1)'(BUFFER_SIZE);
   logic [PACKET_SIZE-1:0] slot  [BUFFER_SIZE];
   logic [PTR_LEN-1:0]     age_q [BUFFER_SIZE];
   logic [PTR_LEN-1:0]     head, tail;
   logic [PTR_LEN:0]       count;
   logic                   err_occ, err_idle, do_wr, do_rd;
   // Finder claims an occupied slot is empty, or reports none empty while room remains.
   assign err_occ   = empty_pos_found && slot[empty_pos][PACKET_SIZE-1];
   assign err_idle  = !empty_pos_found && count < FULL;
   assign do_wr     = in_pkt[PACKET_SIZE-1] && empty_pos_found && !err_occ;
   assign do_rd     = out_valid && out_ready;
   assign out_valid = count != '0;
   assign out_pkt   = out_valid ? slot[age_q[head]] : '0;
   assign in_ready  = empty_pos_found;
   assign occupancy = count;
   for (genvar i = 0; i < BUFFER_SIZE; i++) begin : g_flat
      assign buffer_flat[i*PACKET_SIZE +: PACKET_SIZE] = slot[i];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < BUFFER_SIZE; k++) begin
            slot[k]  <= '0;
            age_q[k] <= '0;
         end
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         protocol_err <= 1'b0;
      end else begin
         if (do_rd) slot[age_q[head]] <= '0;
         if (do_wr) begin
            slot[empty_pos] <= in_pkt;
            age_q[tail]     <= empty_pos;
         end
         head  <= head + PTR_LEN'(do_rd);
         tail  <= tail + PTR_LEN'(do_wr);
         count <= count + (PTR_LEN+1)'(do_wr) - (PTR_LEN+1)'(do_rd);
         if (err_occ || err_idle) protocol_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ring_slot_buffer.sv
// tb_ring_slot_buffer: scoreboard bench with a behavioural empty-slot finder that can be overridden.
module tb_ring_slot_buffer;
   localparam int BS = 4, PS = 49, PL = 2;
   logic               clk = 0, rst_n = 0;
   logic [PS-1:0]      in_pkt = '0, out_pkt;
   logic               in_ready, empty_pos_found, out_valid, out_ready = 0, protocol_err;
   logic [PL-1:0]      empty_pos;
   logic [BS*PS-1:0]   buffer_flat;
   logic [PL:0]        occupancy;
   logic               force_en = 0, force_found = 0, fd_found;
   logic [PL-1:0]      force_pos = '0, fd_pos;
   logic [PS-1:0]      sb [$];
   logic [PS-1:0]      exp_pkt;
   int                 checks = 0, failures = 0, exp_cnt = 0;
   ring_slot_buffer dut (
      .clk(clk), .rst_n(rst_n), .in_pkt(in_pkt), .in_ready(in_ready),
      .empty_pos(empty_pos), .empty_pos_found(empty_pos_found), .buffer_flat(buffer_flat),
      .out_pkt(out_pkt), .out_valid(out_valid), .out_ready(out_ready),
      .occupancy(occupancy), .protocol_err(protocol_err)
   );
   always #5 clk = ~clk;
   always_comb begin
      fd_found = 1'b0;
      fd_pos   = '0;
      for (int i = BS-1; i >= 0; i--)
         if (!buffer_flat[i*PS+PS-1]) begin
            fd_found = 1'b1;
            fd_pos   = PL'(i);
         end
   end
   assign empty_pos       = force_en ? force_pos : fd_pos;
   assign empty_pos_found = force_en ? force_found : fd_found;
   function automatic logic [PS-1:0] pkt(input int x);
      return {1'b1, 48'(x)};
   endfunction
   function automatic logic [PS-1:0] slot_of(input int i);
      return buffer_flat[i*PS +: PS];
   endfunction
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask
   // One clock: score the handshakes at negedge, then return just after the rising edge.
   task automatic cyc();
      logic push, pop;
      @(negedge clk);
      pop  = out_ready && exp_cnt != 0;
      push = in_pkt[PS-1] && fd_found && !force_en;
      chk("out_valid", out_valid, exp_cnt != 0);
      if (pop) begin
         exp_pkt = sb.size() != 0 ? sb.pop_front() : '0;
         chk("out_pkt", out_pkt, exp_pkt);
      end
      if (push) sb.push_back(in_pkt);
      exp_cnt = exp_cnt + int'(push) - int'(pop);
      @(posedge clk);
      #1;
   endtask
   initial begin
      #200000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end
   initial begin
      #12;
      chk("rst_occ", occupancy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_out_pkt", out_pkt, 0);
      chk("rst_err", protocol_err, 0);
      chk("rst_flat_lo", buffer_flat[63:0], 0);
      @(negedge clk) rst_n = 1;
      @(posedge clk) #1;
      chk("rst_in_ready", in_ready, 1);
      // Fill A..D
      for (int i = 0; i < 4; i++) begin
         in_pkt = pkt(32'hA0 + i);
         cyc();
         if (i == 0) chk("latency_A", out_pkt, pkt(32'hA0));
      end
      in_pkt = '0;
      chk("full_occ", occupancy, 4);
      chk("full_in_ready", in_ready, 0);
      chk("full_out_pkt", out_pkt, pkt(32'hA0));
      for (int i = 0; i < 4; i++) chk($sformatf("full_slot%0d", i), slot_of(i), pkt(32'hA0 + i));
      // Drain A, B
      out_ready = 1;
      chk("pop_in_ready_low", in_ready, 0);
      cyc();
      chk("in_ready_after_pop", in_ready, 1);
      cyc();
      out_ready = 0;
      chk("slot0_cleared", slot_of(0), 0);
      chk("slot1_cleared", slot_of(1), 0);
      chk("occ_two", occupancy, 2);
      // Simultaneous push E and pop C at occupancy 2
      out_ready = 1;
      in_pkt = pkt(32'hE0);
      cyc();
      in_pkt = '0;
      chk("simul_occ", occupancy, 2);
      chk("simul_slot0", slot_of(0), pkt(32'hE0));
      chk("simul_slot2", slot_of(2), 0);
      chk("simul_err", protocol_err, 0);
      for (int i = 0; i < 3; i++) cyc();
      out_ready = 0;
      chk("drain_occ", occupancy, 0);
      chk("drain_out_pkt", out_pkt, 0);
      chk("sb_empty", sb.size(), 0);
      // Finder lies about slot 1
      in_pkt = pkt(32'hF0);
      cyc();
      in_pkt = pkt(32'hF1);
      cyc();
      force_en = 1; force_pos = 1; force_found = 1;
      in_pkt = pkt(32'hBAD);
      cyc();
      force_en = 0;
      in_pkt = '0;
      chk("err_set", protocol_err, 1);
      chk("err_slot1", slot_of(1), pkt(32'hF1));
      chk("err_occ", occupancy, 2);
      cyc();
      chk("err_sticky", protocol_err, 1);
      // Reach occupancy 3, then async reset between edges
      in_pkt = pkt(32'hF2);
      cyc();
      in_pkt = '0;
      chk("pre_rst_occ", occupancy, 3);
      #2 rst_n = 0;
      #1;
      chk("async_occ", occupancy, 0);
      chk("async_valid", out_valid, 0);
      chk("async_flat", buffer_flat == '0, 1);
      chk("async_err", protocol_err, 0);
      sb.delete();
      exp_cnt = 0;
      @(negedge clk) rst_n = 1;
      @(posedge clk) #1;
      in_pkt = pkt(32'h77);
      cyc();
      in_pkt = pkt(32'h78);
      cyc();
      in_pkt = '0;
      chk("post_rst_slot0", slot_of(0), pkt(32'h77));
      chk("post_rst_out", out_pkt, pkt(32'h77));
      out_ready = 1;
      for (int i = 0; i < 3; i++) cyc();
      chk("final_occ", occupancy, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
